vp_frame_pad: RTL

// - Single-clock frame conformer between streamScaler output and the display path: forces every frame to exactly OUT_W x OUT_H.
// - Input pixels go through unchanged. Lines and frames are padded when short and cropped when long.
// - Padding uses a constant colour or repeats the last pixel of the line. Output carries sof/eol markers.
// - Successor to the fixed 1280-wide blank filler: parametrised width, channel count and mode, with a valid/ready handshake on both sides.

---
 rtl/vp_frame_pad_pkg.sv | 17 +
 rtl/vp_frame_pad_out_reg.sv | 40 ++++
 rtl/vp_frame_pad.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/vp_frame_pad_pkg.sv
// Shared definitions for the frame conformer: FSM state encoding and pad-mode values.
package vp_frame_pad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACTIVE = 3'd1,
        ST_HPAD   = 3'd2,
        ST_HDROP  = 3'd3,
        ST_VPAD   = 3'd4,
        ST_VDROP  = 3'd5,
        ST_DONE   = 3'd6
    } vp_state_t;

    localparam logic PAD_CONST = 1'b0;
    localparam logic PAD_EDGE  = 1'b1;

endpackage

// File: rtl/vp_frame_pad_out_reg.sv
// Single-stage valid/ready output register; holds its beat stable while the sink stalls.
module vp_frame_pad_out_reg #(
    parameter int PW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [PW-1:0] pix,
    input  logic          sof,
    input  logic          eol,
    input  logic          m_ready,
    output logic          m_valid,
    output logic [PW-1:0] m_data,
    output logic          m_sof,
    output logic          m_eol,
    output logic          can_load
);

    assign can_load = ~m_valid | m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (can_load) begin
            m_valid <= push;
            if (push) begin
                m_data <= pix;
                m_sof  <= sof;
                m_eol  <= eol;
            end
        end
    end

endmodule

// File: rtl/vp_frame_pad.sv
// Frame conformer: passes input pixels through and pads/crops lines and frames to out_w x out_h.
module vp_frame_pad
    import vp_frame_pad_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNELS    = 3,
    parameter int X_RES_WIDTH = 11,
    parameter int Y_RES_WIDTH = 11
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [X_RES_WIDTH-1:0]         in_w_m1,
    input  logic [Y_RES_WIDTH-1:0]         in_h_m1,
    input  logic [X_RES_WIDTH-1:0]         out_w_m1,
    input  logic [Y_RES_WIDTH-1:0]         out_h_m1,
    input  logic                           pad_mode,
    input  logic [DATA_WIDTH*CHANNELS-1:0] fill_color,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_WIDTH*CHANNELS-1:0] s_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_WIDTH*CHANNELS-1:0] m_data,
    output logic                           m_sof,
    output logic                           m_eol,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           drop_err
);

    localparam int PW = DATA_WIDTH * CHANNELS;

    vp_state_t              state, nxt;
    logic [X_RES_WIDTH-1:0] in_w_r, out_w_r, in_x, out_x;
    logic [Y_RES_WIDTH-1:0] in_h_r, out_h_r, in_y, out_y;
    logic                   pad_mode_r, in_done;
    logic [PW-1:0]          fill_r, last_pix, pix;
    logic                   can_load, emit, accept;
    logic                   in_last_x, in_last_y, out_last_x, out_last_y;

    assign in_last_x  = (in_x == in_w_r);
    assign in_last_y  = (in_y == in_h_r);
    assign out_last_x = (out_x == out_w_r);
    assign out_last_y = (out_y == out_h_r);
    assign accept     = s_valid & s_ready;
    assign busy       = (state != ST_IDLE);

    always_comb begin
        nxt     = state;
        s_ready = 1'b0;
        emit    = 1'b0;
        pix     = fill_r;
        case (state)
            ST_ACTIVE: begin
                s_ready = can_load;
                emit    = s_valid & can_load;
                pix     = s_data;
                if (emit) begin
                    if (in_last_x && out_last_x)
                        nxt = out_last_y ? (in_last_y ? ST_DONE : ST_VDROP)
                                         : (in_last_y ? ST_VPAD : ST_ACTIVE);
                    else if (in_last_x)
                        nxt = ST_HPAD;
                    else if (out_last_x)
                        nxt = out_last_y ? ST_VDROP : ST_HDROP;
                end
            end
            ST_HPAD: begin
                emit = can_load;
                pix  = (pad_mode_r == PAD_EDGE) ? last_pix : fill_r;
                if (emit && out_last_x)
                    nxt = out_last_y ? (in_done ? ST_DONE : ST_VDROP)
                                     : (in_done ? ST_VPAD : ST_ACTIVE);
            end
            ST_HDROP: begin
                s_ready = 1'b1;
                if (s_valid && in_last_x)
                    nxt = in_last_y ? ST_VPAD : ST_ACTIVE;
            end
            ST_VPAD: begin
                emit = can_load;
                if (emit && out_last_x && out_last_y)
                    nxt = ST_DONE;
            end
            ST_VDROP: begin
                s_ready = 1'b1;
                if (s_valid && in_last_x && in_last_y)
                    nxt = ST_DONE;
            end
            // Leave only once the final beat has been taken by the sink.
            ST_DONE:  if (can_load) nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
        if (start)
            nxt = ST_ACTIVE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            frame_done <= 1'b0;
        end else begin
            state      <= nxt;
            frame_done <= (state == ST_DONE) && (nxt == ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_w_r     <= '0;
            in_h_r     <= '0;
            out_w_r    <= '0;
            out_h_r    <= '0;
            pad_mode_r <= 1'b0;
            fill_r     <= '0;
            in_x       <= '0;
            in_y       <= '0;
            out_x      <= '0;
            out_y      <= '0;
            in_done    <= 1'b0;
            drop_err   <= 1'b0;
        end else if (start) begin
            in_w_r     <= in_w_m1;
            in_h_r     <= in_h_m1;
            out_w_r    <= out_w_m1;
            out_h_r    <= out_h_m1;
            pad_mode_r <= pad_mode;
            fill_r     <= fill_color;
            in_x       <= '0;
            in_y       <= '0;
            out_x      <= '0;
            out_y      <= '0;
            in_done    <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            if (accept) begin
                if (in_last_x) begin
                    in_x <= '0;
                    if (in_last_y) in_done <= 1'b1;
                    else           in_y    <= in_y + 1'b1;
                end else begin
                    in_x <= in_x + 1'b1;
                end
            end
            if (emit) begin
                if (out_last_x) begin
                    out_x <= '0;
                    if (!out_last_y) out_y <= out_y + 1'b1;
                end else begin
                    out_x <= out_x + 1'b1;
                end
            end
            if (state == ST_IDLE && s_valid)
                drop_err <= 1'b1;
        end
    end

    // Edge-repeat source: most recent pixel taken on the current line.
    always_ff @(posedge clk) begin
        if (accept && state == ST_ACTIVE)
            last_pix <= s_data;
    end

    vp_frame_pad_out_reg #(.PW(PW)) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (start),
        .push     (emit),
        .pix      (pix),
        .sof      ((out_x == '0) && (out_y == '0)),
        .eol      (out_last_x),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_sof    (m_sof),
        .m_eol    (m_eol),
        .can_load (can_load)
    );

endmodule
